// File: rtl/opto_pkg.sv
// Shared derivations for the opto code synthesiser and the downstream angle-calc block.
package opto_pkg;

  localparam int unsigned IDX_W    = 16;
  localparam int unsigned MIN_UNIT = 2;

  function automatic int unsigned norm_codes(input int unsigned tooth_num,
                                             input int unsigned zero_slots);
    return 2 * (tooth_num - zero_slots);
  endfunction

  function automatic int unsigned def_unit(input int unsigned sec2ns,
                                           input int unsigned clk_period_ns,
                                           input int unsigned motor_freq,
                                           input int unsigned tooth_num);
    return sec2ns / clk_period_ns / motor_freq / (2 * tooth_num);
  endfunction

endpackage

// File: rtl/opto_deglitch.sv
// Stability filter: output follows the input only after DEGLITCH_CYC consecutive differing cycles.
module opto_deglitch #(
  parameter int unsigned DEGLITCH_CYC = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_sig
);

  localparam int unsigned CntW = (DEGLITCH_CYC > 1) ? $clog2(DEGLITCH_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sig_q, sig_d;

  always_comb begin
    cnt_d = '0;
    sig_d = sig_q;
    if (i_sig != sig_q) begin
      if (cnt_q == CntW'(DEGLITCH_CYC - 1)) begin
        sig_d = i_sig;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      sig_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sig_q <= sig_d;
    end
  end

  assign o_sig = sig_q;

endmodule

// File: rtl/opto_code_synth.sv
// Encoder opto-switch stage: real code-disk signal or synthesised code train.
// Optional real-path deglitch filter enabled by defining OPTO_DEGLITCH_EN.
module opto_code_synth
  import opto_pkg::*;
#(
  parameter int unsigned SEC2NS_REFVAL = 1_000_000_000,
  parameter int unsigned CLK_PERIOD_NS = 10,
  parameter int unsigned MOTOR_FREQ    = 100,
  parameter int unsigned TOOTH_NUM     = 100,
  parameter int unsigned ZERO_SLOTS    = 2,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned DEGLITCH_CYC  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cal_mode,
  input  logic             i_code_sigin,
  input  logic             i_unit_vld,
  input  logic [CNT_W-1:0] i_unit_cyc,
  output logic             o_opto_switch,
  output logic [IDX_W-1:0] o_code_idx,
  output logic             o_zero_flag,
  output logic             o_rev_pulse,
  output logic             o_cfg_err
);

  localparam int unsigned NormCodes = norm_codes(TOOTH_NUM, ZERO_SLOTS);
  localparam int unsigned LastIdx   = NormCodes + 1;
  localparam int unsigned DefUnit   = def_unit(SEC2NS_REFVAL, CLK_PERIOD_NS, MOTOR_FREQ,
                                               TOOTH_NUM);

  logic [CNT_W-1:0] unit_q, unit_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gen_q, gen_d;
  logic             rev_q, rev_d;
  logic             err_q, err_d;
  logic             opto_q, opto_d;
  logic             sync1_q, sync2_q;
  logic             real_sig;

  logic last_unit, in_zero, code_end, wrap;

  assign last_unit = (cnt_q == unit_q - CNT_W'(1));
  assign in_zero   = (idx_q >= IDX_W'(NormCodes));
  // Zero codes span ZERO_SLOTS unit-passes; slot_q counts the completed passes.
  assign code_end  = last_unit && (!in_zero || (slot_q == IDX_W'(ZERO_SLOTS - 1)));
  assign wrap      = i_cal_mode && code_end && (idx_q == IDX_W'(LastIdx));

`ifdef OPTO_DEGLITCH_EN
  opto_deglitch #(
    .DEGLITCH_CYC(DEGLITCH_CYC)
  ) u_deglitch (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_sig(sync2_q),
    .o_sig(real_sig)
  );
`else
  assign real_sig = sync2_q;
`endif

  always_comb begin
    unit_d     = unit_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = '0;
    slot_d     = '0;
    idx_d      = '0;
    gen_d      = 1'b1;
    rev_d      = 1'b0;

    if (i_cal_mode) begin
      cnt_d  = last_unit ? '0 : cnt_q + CNT_W'(1);
      slot_d = slot_q;
      idx_d  = idx_q;
      gen_d  = gen_q;
      if (code_end) begin
        slot_d = '0;
        gen_d  = ~gen_q;
        idx_d  = wrap ? '0 : idx_q + IDX_W'(1);
      end else if (in_zero && last_unit) begin
        slot_d = slot_q + IDX_W'(1);
      end
      rev_d = wrap;
      if (wrap && pend_vld_q) begin
        unit_d = pend_q;
      end
    end

    // A write landing in the wrap cycle survives the clear and applies at the next wrap.
    err_d = i_unit_vld && (i_unit_cyc < CNT_W'(MIN_UNIT));
    if (i_unit_vld && !err_d) begin
      pend_d     = i_unit_cyc;
      pend_vld_d = 1'b1;
    end else if (wrap) begin
      pend_vld_d = 1'b0;
    end

    opto_d = i_cal_mode ? gen_q : real_sig;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      unit_q     <= CNT_W'(DefUnit);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      slot_q     <= '0;
      idx_q      <= '0;
      gen_q      <= 1'b1;
      rev_q      <= 1'b0;
      err_q      <= 1'b0;
      opto_q     <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
    end else begin
      unit_q     <= unit_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      gen_q      <= gen_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
      opto_q     <= opto_d;
      sync1_q    <= i_code_sigin;
      sync2_q    <= sync1_q;
    end
  end

  assign o_opto_switch = opto_q;
  assign o_code_idx    = idx_q;
  assign o_zero_flag   = in_zero;
  assign o_rev_pulse   = rev_q;
  assign o_cfg_err     = err_q;

endmodule

// File: tb/tb_opto_code_synth.sv
// Directed self-checking bench for opto_code_synth (TOOTH_NUM=4, ZERO_SLOTS=2, unit 3).
module tb_opto_code_synth;

  localparam int unsigned CNT_W = 32;
`ifdef OPTO_DEGLITCH_EN
  localparam int RealLat = 7;
`else
  localparam int RealLat = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cal_mode;
  logic             code_sigin;
  logic             unit_vld;
  logic [CNT_W-1:0] unit_cyc;
  logic             opto_switch;
  logic [15:0]      code_idx;
  logic             zero_flag;
  logic             rev_pulse;
  logic             cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 24/1/1/(2*4) gives a reset unit of 3 clocks.
  opto_code_synth #(
    .SEC2NS_REFVAL(24),
    .CLK_PERIOD_NS(1),
    .MOTOR_FREQ   (1),
    .TOOTH_NUM    (4),
    .ZERO_SLOTS   (2),
    .CNT_W        (CNT_W),
    .DEGLITCH_CYC (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cal_mode   (cal_mode),
    .i_code_sigin (code_sigin),
    .i_unit_vld   (unit_vld),
    .i_unit_cyc   (unit_cyc),
    .o_opto_switch(opto_switch),
    .o_code_idx   (code_idx),
    .o_zero_flag  (zero_flag),
    .o_rev_pulse  (rev_pulse),
    .o_cfg_err    (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (opto_switch !== 1'b1 || code_idx !== 16'd0 || zero_flag !== 1'b0 ||
        rev_pulse !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: opto=%b idx=%0d zero=%b rev=%b err=%b, want 1 0 0 0 0",
               name, opto_switch, code_idx, zero_flag, rev_pulse, cfg_err);
    end
  endtask

  // Runs n_edges generator edges from a revolution start with code length 'unit',
  // optionally writing wr_val before edge wr_at+1.
  task automatic run_rev(input int unit, input int n_edges, input int wr_at, input int wr_val);
    int pos;
    int len;
    int eidx;
    bit prev_lvl;
    bit erev;
    bit ezero;
    bit eerr;
    len = 8 * unit;
    pos = 0;
    prev_lvl = 1'b1;
    for (int i = 0; i < n_edges; i++) begin
      if (i == wr_at) begin
        unit_vld = 1'b1;
        unit_cyc = CNT_W'(wr_val);
      end
      tick();
      unit_vld = 1'b0;
      eerr  = (i == wr_at) && (wr_val < 2);
      pos   = (pos + 1) % len;
      erev  = (pos == 0);
      eidx  = (pos < 4 * unit) ? pos / unit : 4 + (pos - 4 * unit) / (2 * unit);
      ezero = (eidx >= 4);
      checks++;
      if (code_idx !== 16'(eidx) || zero_flag !== ezero || rev_pulse !== erev ||
          opto_switch !== prev_lvl || cfg_err !== eerr) begin
        errors++;
        $display("FAIL gen unit=%0d edge=%0d: idx=%0d zero=%b rev=%b opto=%b err=%b want idx=%0d zero=%b rev=%b opto=%b err=%b",
                 unit, i + 1, code_idx, zero_flag, rev_pulse, opto_switch, cfg_err,
                 eidx, ezero, erev, prev_lvl, eerr);
      end
      prev_lvl = (eidx % 2 == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cal_mode = 1'b0; code_sigin = 1'b1; unit_vld = 1'b0; unit_cyc = '0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("post_reset_idle");
  endtask

  task automatic test_cal_basic();
    unit_vld = 1'b1;
    unit_cyc = CNT_W'(3);
    tick();
    unit_vld = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL valid_write_err: got %b want 0", cfg_err);
    end
    cal_mode = 1'b1;
    run_rev(3, 24, -1, 0);
    run_rev(3, 24, -1, 0);
  endtask

  task automatic test_unit_change();
    run_rev(3, 24, 5, 5);
    run_rev(5, 40, -1, 0);
    run_rev(5, 40, 39, 3);  // write in wrap cycle: defers one revolution
    run_rev(5, 40, -1, 0);
    run_rev(3, 24, -1, 0);
  endtask

  task automatic test_cfg_err();
    run_rev(3, 24, 4, 1);
    run_rev(3, 24, 10, 0);
    run_rev(3, 24, -1, 0);
  endtask

  task automatic test_real_path();
    bit exp;
    cal_mode = 1'b0;
    tick();
    check_reset_vals("cal_exit");
    for (int ph = 0; ph < 2; ph++) begin
      code_sigin = (ph == 1);
      for (int k = 1; k <= RealLat + 1; k++) begin
        tick();
        exp = (k >= RealLat) ? code_sigin : ~code_sigin;
        checks++;
        if (opto_switch !== exp || code_idx !== 16'd0 || rev_pulse !== 1'b0) begin
          errors++;
          $display("FAIL real_path ph=%0d k=%0d: opto=%b idx=%0d rev=%b want opto=%b idx=0 rev=0",
                   ph, k, opto_switch, code_idx, rev_pulse, exp);
        end
      end
    end
    code_sigin = 1'b0;
    repeat (RealLat + 2) tick();
    checks++;
    if (opto_switch !== 1'b0) begin
      errors++;
      $display("FAIL real_low_settle: got %b want 0", opto_switch);
    end
    cal_mode = 1'b1;
    run_rev(3, 24, -1, 0);
  endtask

  task automatic test_reset_mid();
    run_rev(3, 19, -1, 0);
    rst = 1'b1;
    tick();
    check_reset_vals("reset_mid_rev");
    rst = 1'b0;
    run_rev(3, 24, -1, 0);
  endtask

`ifdef OPTO_DEGLITCH_EN
  task automatic test_deglitch();
    bit exp;
    cal_mode = 1'b0;
    code_sigin = 1'b1;
    repeat (10) tick();
    code_sigin = 1'b0;
    repeat (3) tick();
    code_sigin = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (opto_switch !== 1'b1) begin
        errors++;
        $display("FAIL deglitch_short k=%0d: got %b want 1", k, opto_switch);
      end
    end
    code_sigin = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) code_sigin = 1'b1;
      exp = !(k >= 7 && k < 13);
      checks++;
      if (opto_switch !== exp) begin
        errors++;
        $display("FAIL deglitch_long k=%0d: got %b want %b", k, opto_switch, exp);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cal_basic();
    test_unit_change();
    test_cfg_err();
    test_real_path();
    test_reset_mid();
`ifdef OPTO_DEGLITCH_EN
    test_deglitch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
